// File: rtl/sdm_adc_ctrl.sv
// Sequencing controller for the sdm_adc decimator: flush/settle/run FSM,
// gated PDM forwarding and a small output FIFO with valid/ready handshake.
module sdm_adc_ctrl #(
  parameter int unsigned SETTLE_SAMPLES = 8,
  parameter int unsigned FLUSH_CYCLES   = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DW             = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          enable,
  input  logic          pdm_valid,
  input  logic          pdm_din,
  output logic          adc_rst_n,
  output logic          adc_valid_in,
  output logic          adc_din,
  input  logic          adc_valid_out,
  input  logic [DW-1:0] adc_dout,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    state,
  output logic          overflow,
  input  logic          clr_ovf
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  state_t      state_q;
  logic [3:0]  flush_cnt;
  logic [7:0]  settle_cnt;

  assign state = state_q;

  // adc_rst_n is registered alongside the state so it tracks the next state.
  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      state_q    <= IDLE;
      flush_cnt  <= '0;
      settle_cnt <= '0;
      adc_rst_n  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          state_q   <= FLUSH;
          flush_cnt <= '0;
          adc_rst_n <= 1'b0;
        end
        FLUSH: begin
          if (flush_cnt == 4'(FLUSH_CYCLES - 1)) begin
            state_q    <= SETTLE;
            settle_cnt <= '0;
            adc_rst_n  <= 1'b1;
          end else begin
            flush_cnt <= flush_cnt + 4'd1;
            adc_rst_n <= 1'b0;
          end
        end
        SETTLE: begin
          adc_rst_n <= 1'b1;
          if (adc_valid_out) begin
            if (settle_cnt == 8'(SETTLE_SAMPLES - 1)) begin
              state_q    <= RUN;
              settle_cnt <= '0;
            end else begin
              settle_cnt <= settle_cnt + 8'd1;
            end
          end
        end
        RUN: begin
          adc_rst_n <= 1'b1;
        end
        default: begin
          state_q   <= IDLE;
          adc_rst_n <= 1'b0;
        end
      endcase
    end
  end

  logic fwd;
  assign fwd = (state_q == SETTLE) || (state_q == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      adc_valid_in <= 1'b0;
      adc_din      <= 1'b0;
    end else begin
      adc_valid_in <= pdm_valid & fwd;
      adc_din      <= pdm_din & fwd;
    end
  end

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          push;
  logic          pop;
  logic          push_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push    = adc_valid_out && (state_q == RUN);
  assign pop     = !empty && m_ready;
  // A pop on the same edge frees the slot the push overwrites.
  assign push_ok = push && (!full || pop);

  assign m_valid = !empty;
  assign m_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr[AW-1:0]] <= adc_dout;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (push && full && !pop) begin
      overflow <= 1'b1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
    end
  end

endmodule
